// File: rtl/pipe_skid_reg_pkg.sv
// Shared definitions for the inter-stage pipeline register: FSM states,
// EX/MEM control-bit positions and default widths.
package pipe_pkg;
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    localparam int CTL_REGWRITE = 0;
    localparam int CTL_MEMTOREG = 1;
    localparam int CTL_MEMREAD  = 2;
    localparam int CTL_MEMWRITE = 3;

    localparam int DEF_CTRL_W   = 4;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_DATA = 2;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_CNT_W    = 16;
endpackage

// File: rtl/pipe_payload_reg.sv
// One beat of storage {ctrl, data, rd}: loads on load_i, else holds;
// cleared by the synchronous active-low reset.
module pipe_payload_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W   = DEF_CTRL_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_DATA = DEF_NUM_DATA,
    parameter int ADDR_W   = DEF_ADDR_W
) (
    input  logic                       clk_i,
    input  logic                       start_i,
    input  logic                       load_i,
    input  logic [CTRL_W-1:0]          ctrl_i,
    input  logic [NUM_DATA*DATA_W-1:0] data_i,
    input  logic [ADDR_W-1:0]          rd_i,
    output logic [CTRL_W-1:0]          ctrl_o,
    output logic [NUM_DATA*DATA_W-1:0] data_o,
    output logic [ADDR_W-1:0]          rd_o
);
    logic [CTRL_W-1:0]          ctrl_d, ctrl_q;
    logic [NUM_DATA*DATA_W-1:0] data_d, data_q;
    logic [ADDR_W-1:0]          rd_d, rd_q;

    always_comb begin
        ctrl_d = ctrl_q;
        data_d = data_q;
        rd_d   = rd_q;
        if (load_i) begin
            ctrl_d = ctrl_i;
            data_d = data_i;
            rd_d   = rd_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!start_i) begin
            ctrl_q <= '0;
            data_q <= '0;
            rd_q   <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            data_q <= data_d;
            rd_q   <= rd_d;
        end
    end

    assign ctrl_o = ctrl_q;
    assign data_o = data_q;
    assign rd_o   = rd_q;
endmodule

// File: rtl/pipe_skid_reg.sv
// Valid/ready pipeline register with a 2-entry skid buffer, synchronous flush
// and a saturating backpressure counter. Main entry always drives the outputs.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W   = DEF_CTRL_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_DATA = DEF_NUM_DATA,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                       clk_i,
    input  logic                       start_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic [CTRL_W-1:0]          ctrl_i,
    input  logic [NUM_DATA*DATA_W-1:0] data_i,
    input  logic [ADDR_W-1:0]          rd_i,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [CTRL_W-1:0]          ctrl_o,
    output logic [NUM_DATA*DATA_W-1:0] data_o,
    output logic [ADDR_W-1:0]          rd_o,
    input  logic                       flush_i,
    output logic [CNT_W-1:0]           stall_cnt_o
);
    state_e             state_d, state_q;
    logic               ready_d, ready_q;
    logic [CNT_W-1:0]   stall_cnt_d, stall_cnt_q;
    logic               in_xfer, out_xfer;
    logic               load_main, load_skid, main_from_skid;

    logic [CTRL_W-1:0]          main_ctrl, skid_ctrl, main_ctrl_in;
    logic [NUM_DATA*DATA_W-1:0] main_data, skid_data, main_data_in;
    logic [ADDR_W-1:0]          main_rd, skid_rd, main_rd_in;

    assign valid_o  = (state_q != ST_EMPTY);
    assign in_xfer  = valid_i & ready_q;
    assign out_xfer = valid_o & ready_i;

    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            ST_EMPTY: if (in_xfer) begin
                state_d   = ST_ONE;
                load_main = 1'b1;
            end
            ST_ONE: begin
                if (in_xfer && out_xfer) begin
                    load_main = 1'b1;
                end else if (out_xfer) begin
                    state_d = ST_EMPTY;
                end else if (in_xfer) begin
                    state_d   = ST_TWO;
                    load_skid = 1'b1;
                end
            end
            ST_TWO: if (out_xfer) begin
                state_d        = ST_ONE;
                load_main      = 1'b1;
                main_from_skid = 1'b1;
            end
            default: state_d = ST_EMPTY;
        endcase
        // Flush drops everything, including a beat arriving this cycle.
        if (flush_i) begin
            state_d   = ST_EMPTY;
            load_main = 1'b0;
            load_skid = 1'b0;
        end
        ready_d = (state_d != ST_TWO);

        stall_cnt_d = stall_cnt_q;
        if (valid_o && !ready_i && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!start_i) begin
            state_q     <= ST_EMPTY;
            ready_q     <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign main_ctrl_in = main_from_skid ? skid_ctrl : ctrl_i;
    assign main_data_in = main_from_skid ? skid_data : data_i;
    assign main_rd_in   = main_from_skid ? skid_rd   : rd_i;

    pipe_payload_reg #(
        .CTRL_W(CTRL_W), .DATA_W(DATA_W), .NUM_DATA(NUM_DATA), .ADDR_W(ADDR_W)
    ) u_main (
        .clk_i(clk_i), .start_i(start_i), .load_i(load_main),
        .ctrl_i(main_ctrl_in), .data_i(main_data_in), .rd_i(main_rd_in),
        .ctrl_o(main_ctrl), .data_o(main_data), .rd_o(main_rd)
    );

    pipe_payload_reg #(
        .CTRL_W(CTRL_W), .DATA_W(DATA_W), .NUM_DATA(NUM_DATA), .ADDR_W(ADDR_W)
    ) u_skid (
        .clk_i(clk_i), .start_i(start_i), .load_i(load_skid),
        .ctrl_i(ctrl_i), .data_i(data_i), .rd_i(rd_i),
        .ctrl_o(skid_ctrl), .data_o(skid_data), .rd_o(skid_rd)
    );

    assign ready_o     = ready_q;
    assign ctrl_o      = valid_o ? main_ctrl : '0;
    assign data_o      = main_data;
    assign rd_o        = main_rd;
    assign stall_cnt_o = stall_cnt_q;
endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg; a second instance with a 3-bit stall
// counter shares the stimulus to exercise saturation.
module tb_pipe_skid_reg;
    import pipe_pkg::*;

    logic        clk = 1'b0;
    logic        start_i, valid_i, ready_i, flush_i;
    logic [3:0]  ctrl_i;
    logic [63:0] data_i;
    logic [4:0]  rd_i;

    logic        ready_o, valid_o;
    logic [3:0]  ctrl_o;
    logic [63:0] data_o;
    logic [4:0]  rd_o;
    logic [15:0] stall_cnt_o;

    logic        s_ready_o, s_valid_o;
    logic [3:0]  s_ctrl_o;
    logic [63:0] s_data_o;
    logic [4:0]  s_rd_o;
    logic [2:0]  s_stall_cnt_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_skid_reg dut (
        .clk_i(clk), .start_i(start_i), .valid_i(valid_i), .ready_o(ready_o),
        .ctrl_i(ctrl_i), .data_i(data_i), .rd_i(rd_i),
        .valid_o(valid_o), .ready_i(ready_i), .ctrl_o(ctrl_o),
        .data_o(data_o), .rd_o(rd_o), .flush_i(flush_i), .stall_cnt_o(stall_cnt_o)
    );

    pipe_skid_reg #(.CNT_W(3)) dut_sat (
        .clk_i(clk), .start_i(start_i), .valid_i(valid_i), .ready_o(s_ready_o),
        .ctrl_i(ctrl_i), .data_i(data_i), .rd_i(rd_i),
        .valid_o(s_valid_o), .ready_i(ready_i), .ctrl_o(s_ctrl_o),
        .data_o(s_data_o), .rd_o(s_rd_o), .flush_i(flush_i), .stall_cnt_o(s_stall_cnt_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; checks afterwards see the post-edge state.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [4:0] rd, input logic [3:0] ctrl);
        valid_i = 1'b1;
        rd_i    = rd;
        ctrl_i  = ctrl;
        data_i  = {27'd0, rd, 27'h7ffffff, ~rd};
    endtask

    initial begin
        start_i = 1'b0; valid_i = 1'b1; ready_i = 1'b1; flush_i = 1'b0;
        ctrl_i = 4'hf; data_i = 64'hdead_beef_cafe_f00d; rd_i = 5'd3;

        // Reset held for two edges with valid_i high
        step(); step();
        chk("rst_valid", valid_o, 1'b0);
        chk("rst_ready", ready_o, 1'b0);
        chk("rst_ctrl", ctrl_o, 4'h0);
        chk("rst_data", data_o, 64'h0);
        chk("rst_rd", rd_o, 5'd0);
        chk("rst_stall", stall_cnt_o, 16'd0);
        start_i = 1'b1; valid_i = 1'b0;
        step();
        chk("rel_ready", ready_o, 1'b1);
        chk("rel_valid", valid_o, 1'b0);

        // Streaming with ready_i high: each beat appears right after its edge
        for (int i = 1; i <= 8; i++) begin
            beat(5'(i), 4'(i));
            step();
            chk("stream_valid", valid_o, 1'b1);
            chk("stream_rd", rd_o, 5'(i));
            chk("stream_data", data_o, {27'd0, 5'(i), 27'h7ffffff, ~5'(i)});
            chk("stream_ready", ready_o, 1'b1);
        end
        valid_i = 1'b0;
        step();
        chk("stream_end_valid", valid_o, 1'b0);
        chk("stream_stall", stall_cnt_o, 16'd0);

        // Backpressure: A then B with ready_i low
        ready_i = 1'b0;
        beat(5'd10, 4'h1);
        step();
        chk("bp_a_ready", ready_o, 1'b1);
        chk("bp_a_rd", rd_o, 5'd10);
        beat(5'd11, 4'h2);
        step();
        chk("bp_b_ready", ready_o, 1'b0);
        chk("bp_b_rd", rd_o, 5'd10);
        chk("bp_b_stall", stall_cnt_o, 16'd1);
        beat(5'd12, 4'h3);  // offered while full; must not be taken
        step();
        chk("bp_hold_rd", rd_o, 5'd10);
        chk("bp_hold_stall", stall_cnt_o, 16'd2);
        valid_i = 1'b0;
        ready_i = 1'b1;
        step();
        chk("bp_drain_b", rd_o, 5'd11);
        chk("bp_drain_ctrl", ctrl_o, 4'h2);
        chk("bp_drain_ready", ready_o, 1'b1);
        step();
        chk("bp_empty", valid_o, 1'b0);
        chk("bp_stall_final", stall_cnt_o, 16'd2);
        chk("bp_sat_stall", s_stall_cnt_o, 3'd2);

        // Flush while holding two beats, with C offered in the same cycle
        ready_i = 1'b0;
        beat(5'd20, 4'h1);
        step();
        beat(5'd21, 4'h2);
        step();
        chk("fl_full", ready_o, 1'b0);
        flush_i = 1'b1;
        beat(5'd22, 4'hf);
        step();
        chk("fl_valid", valid_o, 1'b0);
        chk("fl_ctrl", ctrl_o, 4'h0);
        chk("fl_ready", ready_o, 1'b1);
        chk("fl_rd_hold", rd_o, 5'd20);
        chk("fl_stall", stall_cnt_o, 16'd4);
        flush_i = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fl_no_c", valid_o, 1'b0);
        end

        // Bubble gating of control bits
        beat(5'd5, 4'b1111);
        step();
        chk("bub_ctrl_on", ctrl_o, 4'b1111);
        valid_i = 1'b0;
        step();
        chk("bub_valid", valid_o, 1'b0);
        chk("bub_ctrl_off", ctrl_o, 4'b0000);

        // Reset clears counters, then saturation on the 3-bit instance
        start_i = 1'b0;
        step();
        start_i = 1'b1;
        step();
        ready_i = 1'b0;
        beat(5'd7, 4'h4);
        step();
        valid_i = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("sat_cnt3", s_stall_cnt_o, 3'd7);
        chk("sat_cnt16", stall_cnt_o, 16'd10);
        chk("sat_valid", valid_o, 1'b1);

        // Reset mid-operation drops the held beat
        start_i = 1'b0;
        step();
        chk("midrst_valid", valid_o, 1'b0);
        chk("midrst_stall", stall_cnt_o, 16'd0);
        chk("midrst_rd", rd_o, 5'd0);
        start_i = 1'b1;
        ready_i = 1'b1;
        step();
        chk("midrst_ready", ready_o, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised inter-stage pipeline register, successor to the fixed EX/MEM latch. It carries control bits, N data lanes and a destination register address between two pipeline stages. It adds a valid/ready handshake with a 2-entry skid buffer, so backpressure never drops a beat. It also adds synchronous flush (bubble insertion) and a saturating stall counter. One instance is used per stage boundary: ID/EX, EX/MEM and MEM/WB.

## Interface
- CTRL_W, 4, control bits per beat (EX/MEM: RegWrite, MemtoReg, MemRead, MemWrite)
- DATA_W, 32, width of one data lane
- NUM_DATA, 2, number of data lanes (EX/MEM: ALU result, store data)
- ADDR_W, 5, destination register address width
- CNT_W, 16, stall counter width
- clk_i  in  1  clock; all state updates on its rising edge
- start_i  in  1  reset; synchronous, active-low
- valid_i  in  1  upstream beat valid
- ready_o  out  1  upstream may transfer (registered)
- ctrl_i  in  CTRL_W  control bits of incoming beat
- data_i  in  NUM_DATA*DATA_W  data lanes; lane k at bits [k*DATA_W +: DATA_W]
- rd_i  in  ADDR_W  destination register address
- valid_o  out  1  downstream beat valid
- ready_i  in  1  downstream accepts
- ctrl_o  out  CTRL_W  control bits; forced to 0 whenever valid_o=0
- data_o  out  NUM_DATA*DATA_W  data lanes of head beat
- rd_o  out  ADDR_W  destination address of head beat
- flush_i  in  1  discard all held beats
- stall_cnt_o  out  CNT_W  saturating count of backpressured cycles

## Operation
- Storage: main entry (drives outputs) plus one skid entry. State is EMPTY, ONE or TWO.
- Upstream transfer: valid_i & ready_o. Downstream transfer: valid_o & ready_i.
- EMPTY: in → ONE, main ← input.
- ONE:
  - in & out → ONE, main ← input.
  - out only → EMPTY.
  - in only → TWO, skid ← input.
- TWO: no upstream transfer is possible (ready_o=0). out → ONE, main ← skid.
- valid_o = (state ≠ EMPTY). ready_o is registered as (next state ≠ TWO).
- flush_i=1: next state EMPTY, ready_o ← 1. Any upstream transfer in the same cycle is discarded. Payload registers keep their values; ctrl_o reads 0 through gating.
- Priority: reset > flush > handshake.
- Payload registers load only when they capture a beat; otherwise they hold. data_o and rd_o need not be 0 when valid_o=0.
- stall_cnt_o increments when valid_o & ~ready_i. It saturates at 2^CNT_W−1 and is unaffected by flush.
- Ordering: beats leave in acceptance order; no beat is duplicated or lost except by flush.

## Timing
- Latency: a beat accepted at edge n is visible on the outputs after edge n. Zero bubbles when ready_i is held at 1.
- Throughput: 1 beat/cycle sustained.
- ready_o falls the cycle after the skid entry fills. It rises the cycle after the skid entry drains.
- Reset, with start_i sampled low at an edge:
  - state EMPTY, valid_o=0, ready_o=0, ctrl_o=0, data_o=0, rd_o=0, stall_cnt_o=0, skid payload=0.
  - At the first edge with start_i high, ready_o ← 1.
- Reset mid-operation: all held beats are lost with no partial output. Behaviour is identical to power-up reset.
- Simultaneous flush and downstream transfer: the downstream beat counts as transferred. State is still EMPTY next cycle.

## Structure
- Shared package pipe_pkg:
  - state enum {ST_EMPTY, ST_ONE, ST_TWO}.
  - EX/MEM control bit indices CTL_REGWRITE=0, CTL_MEMTOREG=1, CTL_MEMREAD=2, CTL_MEMWRITE=3.
  - Default widths.
- Sub-module pipe_payload_reg: a load-enabled, synchronously reset register for {ctrl, data, rd}. It is instantiated twice, for main and skid.
- The top level holds the FSM, the ready_o register, the stall counter and output gating.

## Test plan
- Reset: start_i low for 2 edges with valid_i=1 → valid_o=0, ctrl_o=0, data_o=0, stall_cnt_o=0, ready_o=0. ready_o=1 one edge after release.
- Streaming: 8 beats with rd_i=1..8, ready_i=1 → rd_o=1..8 on consecutive cycles, each one cycle after acceptance, with no gaps.
- Backpressure: ready_i=0 while beats A,B are sent → ready_o=0 after B. Raise ready_i → A then B delivered; ready_o returns to 1; stall_cnt_o equals the number of ready_i=0 cycles with valid_o=1.
- Flush in TWO: hold beats A,B, pulse flush_i with valid_i=1 carrying C → next cycle valid_o=0, ctrl_o=0, ready_o=1. C is never output.
- Bubble gating: ctrl_i=4'b1111 accepted, then drained with no new input → ctrl_o=4'b0000 while valid_o=0.
- Saturation: CNT_W=3, ready_i=0 with valid_o=1 for 10 cycles → stall_cnt_o stops at 7.
